// File: rtl/spi_capture_fifo.sv
// SPI-style serial capture: oversampled sclk/sdata, word assembly, FIFO.
// Ports: clk/resetb, sclk_in/sdata_in[/csn_in], out_* stream, level, sticky flags. Opt: SPI_CAP_CS_EN.
module spi_capture_fifo #(
  parameter int WORD_W      = 8,
  parameter int DEPTH       = 16,
  parameter int SAMPLE_EDGE = 0,
  parameter int LSB_FIRST   = 0
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    sclk_in,
  input  logic                    sdata_in,
`ifdef SPI_CAP_CS_EN
  input  logic                    csn_in,
`endif
  output logic [WORD_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    frame_err,
  input  logic                    clr_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

  logic sclk_s1, sclk_s2, sclk_d;
  logic sdata_s1, sdata_s2;
  logic smp;
  logic active;

  logic [WORD_W-1:0] sr, sr_nx;
  logic [CW-1:0]     bit_cnt, cnt_nx;
  logic              push;
  logic              ferr_set;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, rd_nx, count, cnt_left;
  logic              full, pop, wr_en, ovf_set;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_d   <= 1'b0;
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
    end else begin
      sclk_s1  <= sclk_in;
      sclk_s2  <= sclk_s1;
      sclk_d   <= sclk_s2;
      sdata_s1 <= sdata_in;
      sdata_s2 <= sdata_s1;
    end
  end

`ifdef SPI_CAP_CS_EN
  logic csn_s1, csn_s2, csn_d;
  logic csn_rise, csn_fall;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      csn_s1 <= 1'b1;
      csn_s2 <= 1'b1;
      csn_d  <= 1'b1;
    end else begin
      csn_s1 <= csn_in;
      csn_s2 <= csn_s1;
      csn_d  <= csn_s2;
    end
  end

  assign active   = ~csn_s2;
  assign csn_rise = csn_s2 & ~csn_d;
  assign csn_fall = ~csn_s2 & csn_d;
`else
  assign active = 1'b1;
`endif

  assign smp = active & ((SAMPLE_EDGE != 0) ?
                         (sclk_d & ~sclk_s2) :
                         (sclk_s2 & ~sclk_d));

  always_comb begin
    sr_nx    = sr;
    cnt_nx   = bit_cnt;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (smp) begin
      sr_nx = (LSB_FIRST != 0) ?
              {sdata_s2, sr[WORD_W-1:1]} :
              {sr[WORD_W-2:0], sdata_s2};
      if (bit_cnt == LAST) begin
        push   = 1'b1;
        cnt_nx = '0;
      end else begin
        cnt_nx = bit_cnt + CW'(1);
      end
    end
`ifdef SPI_CAP_CS_EN
    // Frame boundaries realign the word; a short frame is an error.
    if (csn_rise) begin
      ferr_set = (bit_cnt != '0);
      cnt_nx   = '0;
      sr_nx    = '0;
    end else if (csn_fall) begin
      cnt_nx = '0;
      sr_nx  = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr      <= sr_nx;
      bit_cnt <= cnt_nx;
    end
  end

  assign count    = wr_ptr - rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = out_valid & out_ready;
  assign wr_en    = push & (~full | pop);
  assign ovf_set  = push & full & ~pop;
  assign rd_nx    = rd_ptr + (AW+1)'(pop);
  // Entries left after this cycle's pop; this cycle's push is not visible yet.
  assign cnt_left = count - (AW+1)'(pop);
  assign level    = count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= sr_nx;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      rd_ptr    <= rd_nx;
      out_valid <= (cnt_left != '0);
      if (cnt_left != '0) out_data <= mem[rd_nx[AW-1:0]];
      overflow  <= ovf_set | (overflow & ~clr_sticky);
    end
  end

`ifdef SPI_CAP_CS_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) frame_err <= 1'b0;
    else         frame_err <= ferr_set | (frame_err & ~clr_sticky);
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule
